// File: rtl/cordic_pkg.sv
// Shared constants and state type for the CORDIC phase source and its sideband logic.
package cordic_pkg;

   localparam int PHASE_W    = 16;
   localparam int CORDIC_LAT = 14;
   localparam int OUT_W      = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_chirp_phase_gen_if.sv
// Control, sweep-parameter and sample-stream signals of the chirp phase generator.
interface cordic_chirp_phase_gen_if #(
   parameter int PHASE_W = 16,
   parameter int ACC_W   = 32,
   parameter int CNT_W   = 20
);
   logic               start;
   logic               abort;
   logic [ACC_W-1:0]   ftw_start;
   logic [ACC_W-1:0]   ftw_step;
   logic [CNT_W-1:0]   sweep_len;
   logic [PHASE_W-1:0] phase_ofs;
   logic [PHASE_W-1:0] arg;
   logic               arg_valid;
   logic               out_valid;
   logic               out_last;
   logic               busy;
   logic               done;

   modport master (
      output start, abort, ftw_start, ftw_step, sweep_len, phase_ofs,
      input  arg, arg_valid, out_valid, out_last, busy, done
   );

   modport slave (
      input  start, abort, ftw_start, ftw_step, sweep_len, phase_ofs,
      output arg, arg_valid, out_valid, out_last, busy, done
   );
endinterface

// File: rtl/cordic_lat_match.sv
// Width-2 shift register that carries sideband alongside the CORDIC pipeline.
module cordic_lat_match #(
   parameter int DEPTH = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic [1:0] din,
   output logic [1:0] dout
);
   logic [DEPTH-1:0][1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (flush) begin
         sr <= '0;
      end else begin
         sr <= {sr[DEPTH-2:0], din};
      end
   end

   assign dout = sr[DEPTH-1];
endmodule

// File: rtl/cordic_chirp_phase_gen.sv
// Chirp phase accumulator feeding the CORDIC arg input, with latency-matched valid/last.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   SWEEP | emitting one arg sample per clock
//   DRAIN | waiting for the final sample to leave the CORDIC pipeline
module cordic_chirp_phase_gen #(
   parameter int PHASE_W    = cordic_pkg::PHASE_W,
   parameter int ACC_W      = 32,
   parameter int CNT_W      = 20,
   parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   cordic_chirp_phase_gen_if.slave   bus
);
   import cordic_pkg::*;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   ftw;
   logic [ACC_W-1:0]   step;
   logic [PHASE_W-1:0] ofs;
   logic [CNT_W-1:0]   remain;
   logic [PHASE_W-1:0] arg_q;
   logic               arg_valid_q;
   logic               last_q;
   logic [1:0]         dl_out;
   logic               done_w;

   // Sample 0 is issued on the accept edge, so acc/ftw are preloaded one step ahead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         ftw         <= '0;
         step        <= '0;
         ofs         <= '0;
         remain      <= '0;
         arg_q       <= '0;
         arg_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end else if (bus.abort) begin
         state       <= IDLE;
         arg_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && (bus.sweep_len != '0)) begin
                  acc         <= bus.ftw_start;
                  ftw         <= bus.ftw_start + bus.ftw_step;
                  step        <= bus.ftw_step;
                  ofs         <= bus.phase_ofs;
                  remain      <= bus.sweep_len - CNT_W'(1);
                  arg_q       <= bus.phase_ofs;
                  arg_valid_q <= 1'b1;
                  last_q      <= (bus.sweep_len == CNT_W'(1));
                  state       <= SWEEP;
               end
            end
            SWEEP: begin
               if (remain == '0) begin
                  arg_valid_q <= 1'b0;
                  last_q      <= 1'b0;
                  state       <= DRAIN;
               end else begin
                  arg_q       <= ofs + acc[ACC_W-1 -: PHASE_W];
                  acc         <= acc + ftw;
                  ftw         <= ftw + step;
                  remain      <= remain - CNT_W'(1);
                  last_q      <= (remain == CNT_W'(1));
                  arg_valid_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (done_w) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   cordic_lat_match #(.DEPTH(CORDIC_LAT)) u_lat (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.abort),
      .din   ({arg_valid_q, last_q}),
      .dout  (dl_out)
   );

   assign done_w        = dl_out[1] && dl_out[0] && (state == DRAIN);
   assign bus.arg       = arg_q;
   assign bus.arg_valid = arg_valid_q;
   assign bus.out_valid = dl_out[1];
   assign bus.out_last  = dl_out[0];
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_w;
endmodule
